fpu_req_arbiter: RTL



---
 rtl/fpu_req_arbiter_if.sv | 40 ++++
 rtl/fpu_req_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/fpu_req_arbiter_if.sv
// Bundles requester command/response ports and the shared FPU control port.
// Latency: none, wires only.
// Backpressure: carries valid/ready on both requester sides; FPU side uses done.
interface fpu_req_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32,
    parameter int OP_W   = 7
);
    logic [N_REQ-1:0]        req_valid_i;
    logic [N_REQ-1:0]        req_ready_o;
    logic [N_REQ*OP_W-1:0]   req_op_i;
    logic [N_REQ*DATA_W-1:0] req_opa_i;
    logic [N_REQ*DATA_W-1:0] req_opb_i;
    logic [N_REQ-1:0]        rsp_valid_o;
    logic [N_REQ-1:0]        rsp_ready_i;
    logic [DATA_W-1:0]       rsp_data_o;
    logic [1:0]              rsp_err_o;
    logic                    fpu_en_o;
    logic [OP_W-1:0]         fpu_op_o;
    logic [DATA_W-1:0]       fpu_opa_o;
    logic [DATA_W-1:0]       fpu_opb_o;
    logic                    fpu_done_i;
    logic [DATA_W-1:0]       fpu_result_i;

    // Arbiter side.
    modport slave (
        input  req_valid_i, req_op_i, req_opa_i, req_opb_i, rsp_ready_i,
               fpu_done_i, fpu_result_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               fpu_en_o, fpu_op_o, fpu_opa_o, fpu_opb_o
    );

    // Requesters plus FPU side.
    modport master (
        output req_valid_i, req_op_i, req_opa_i, req_opb_i, rsp_ready_i,
               fpu_done_i, fpu_result_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o,
               fpu_en_o, fpu_op_o, fpu_opa_o, fpu_opb_o
    );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Round-robin sharing of one FPU among N_REQ requesters, with opcode check and watchdog.
// Latency: accept->fpu_en 1 cycle; done->rsp_valid 1 cycle; illegal op->rsp_valid 1 cycle.
// Backpressure: one op in flight; req_ready only in IDLE; response held until rsp_ready of the grantee.
module fpu_req_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 32,
    parameter int OP_W    = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              fpu_clk,
    input  logic              fpu_rst_n,
    fpu_req_arbiter_if.slave  bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [15:0]      WDOG_LAST = 16'(TIMEOUT - 1);
    localparam logic [N_REQ-1:0] ONE_OH    = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant;
    logic [15:0]       wdog;

    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic [OP_W-1:0]   win_op;
    logic [DATA_W-1:0] win_opa;
    logic [DATA_W-1:0] win_opb;
    logic              win_legal;
    logic [N_REQ-1:0]  win_oh;
    logic [N_REQ-1:0]  grant_oh;
    logic [IDX_W-1:0]  rr_next;

    // Pick the first valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [IDX_W-1:0] cand;
        cand    = '0;
        win_vld = 1'b0;
        win_idx = '0;
        // Scan from farthest to nearest so the nearest valid requester is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(rr_ptr) + i) % N_REQ);
            if (bus.req_valid_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Mux out the winner's opcode and operands.
    always_comb begin
        win_op  = '0;
        win_opa = '0;
        win_opb = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (IDX_W'(k) == win_idx) begin
                win_op  = bus.req_op_i[k*OP_W +: OP_W];
                win_opa = bus.req_opa_i[k*DATA_W +: DATA_W];
                win_opb = bus.req_opb_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Opcode must have exactly one bit set; zero or several bits are rejected.
    assign win_legal = (win_op != '0) && ((win_op & (win_op - 1'b1)) == '0);
    assign win_oh    = ONE_OH << win_idx;
    assign grant_oh  = ONE_OH << grant;
    assign rr_next   = (grant == IDX_W'(N_REQ - 1)) ? '0 : grant + 1'b1;

    // Accept is combinational in IDLE; held low during reset so every output reads 0.
    always_comb begin
        bus.req_ready_o = '0;
        if (fpu_rst_n && (state == ST_IDLE) && win_vld) begin
            bus.req_ready_o[win_idx] = 1'b1;
        end
    end

    // Main sequencer: latch request, drive the FPU, hold the response until accepted.
    always_ff @(posedge fpu_clk or negedge fpu_rst_n) begin
        if (!fpu_rst_n) begin
            state           <= ST_IDLE;
            rr_ptr          <= '0;
            grant           <= '0;
            wdog            <= '0;
            bus.rsp_valid_o <= '0;
            bus.rsp_data_o  <= '0;
            bus.rsp_err_o   <= ERR_OK;
            bus.fpu_en_o    <= 1'b0;
            bus.fpu_op_o    <= '0;
            bus.fpu_opa_o   <= '0;
            bus.fpu_opb_o   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        grant         <= win_idx;
                        bus.fpu_op_o  <= win_op;
                        bus.fpu_opa_o <= win_opa;
                        bus.fpu_opb_o <= win_opb;
                        if (win_legal) begin
                            state        <= ST_BUSY;
                            wdog         <= '0;
                            bus.fpu_en_o <= 1'b1;
                        end else begin
                            // Malformed opcode: answer directly, FPU never sees it.
                            state           <= ST_RESP;
                            bus.rsp_valid_o <= win_oh;
                            bus.rsp_err_o   <= ERR_ILLEGAL;
                            bus.rsp_data_o  <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    wdog <= wdog + 1'b1;
                    // Completion wins over a watchdog expiry in the same cycle.
                    if (bus.fpu_done_i) begin
                        state           <= ST_RESP;
                        bus.fpu_en_o    <= 1'b0;
                        bus.rsp_valid_o <= grant_oh;
                        bus.rsp_err_o   <= ERR_OK;
                        bus.rsp_data_o  <= bus.fpu_result_i;
                    end else if (wdog == WDOG_LAST) begin
                        state           <= ST_RESP;
                        bus.fpu_en_o    <= 1'b0;
                        bus.rsp_valid_o <= grant_oh;
                        bus.rsp_err_o   <= ERR_TIMEOUT;
                        bus.rsp_data_o  <= '0;
                    end
                end
                ST_RESP: begin
                    // Only the grantee's ready matters; pointer moves past it on hand-off.
                    if (bus.rsp_ready_i[grant]) begin
                        state           <= ST_IDLE;
                        bus.rsp_valid_o <= '0;
                        rr_ptr          <= rr_next;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
